riscv_fetch: RTL and testbench
==============================

Name: riscv_fetch

Overview:
Instruction fetch stage directly upstream of the control/decode block. It owns the PC, issues one word-aligned read at a time to instruction memory, and delivers the returned 32-bit instruction plus its PC to decode over a valid/ready handshake. It supports redirect (branch/jump target from the datapath) with cancellation of in-flight fetches.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; must be 4-byte aligned.
XLEN, 32, address and instruction width; only 32 is supported.

Ports:
clock  input  1  single clock, rising edge.
resetn  input  1  asynchronous active-low reset.
run  input  1  fetch enable; 0 stops issuing new requests.
redirect  input  1  one-cycle pulse: load redirect_pc into the PC and flush.
redirect_pc  input  32  new fetch target.
mem_req  output  1  read request to instruction memory.
mem_addr  output  32  request address; stable while mem_req=1.
mem_ack  input  1  memory response; mem_rdata is valid in the same cycle.
mem_rdata  input  32  instruction word returned.
ir  output  32  fetched instruction to decode.
ir_pc  output  32  address of ir.
ir_valid  output  1  ir/ir_pc hold a valid instruction.
ir_ready  input  1  decode accepts ir this cycle.
fault  output  1  sticky misaligned-redirect flag.

Behaviour:
- Reset (async, resetn=0): state=IDLE; PC=RESET_PC; mem_req=0; mem_addr=RESET_PC; ir=32'h00000013 (NOP); ir_pc=0; ir_valid=0; fault=0; kill=0. Reset while a request is outstanding abandons it; memory must tolerate this.
- FSM states:
  - IDLE: if run=1 and fault=0, go to REQ, with mem_addr<=PC and mem_req<=1 on the next edge.
  - REQ: mem_req=1 and mem_addr held until mem_ack. On mem_ack:
    - kill=0: ir<=mem_rdata, ir_pc<=mem_addr, PC<=mem_addr+4, ir_valid<=1, go to HOLD.
    - kill=1: discard the data, clear kill, go to IDLE.
  - HOLD: ir_valid=1; ir/ir_pc stable until ir_ready=1. On ir_ready: ir_valid<=0. If run=1, go to REQ with mem_addr<=PC; otherwise go to IDLE.
- Latency and throughput:
  - First request is asserted 1 cycle after leaving IDLE.
  - ir_valid rises on the edge after mem_ack.
  - With a zero-wait memory (ack in the first cycle of mem_req) and ir_ready held at 1, sustained throughput is 1 instruction per 2 cycles.
- PC arithmetic: 32-bit unsigned, +4, wraps 32'hFFFFFFFC -> 32'h00000000 silently.
- Redirect (highest priority), PC<=redirect_pc:
  - In IDLE: the next request uses the new PC.
  - In REQ without ack in the same cycle: set kill. mem_req and mem_addr stay unchanged until ack, because a request is never withdrawn.
  - In REQ with ack in the same cycle: discard the data and go to IDLE.
  - In HOLD: ir_valid<=0 next cycle and go to IDLE. If ir_ready=1 in the same cycle, the instruction counts as consumed by decode.
- Misaligned redirect (redirect_pc[1:0]!=0): fault<=1, PC<=redirect_pc. Any in-flight request is still killed. No new request is issued until a later aligned redirect clears fault.
- run=0 never aborts an outstanding request or a held instruction; it only blocks transitions into REQ.
- mem_req never deasserts without mem_ack, except on reset.

Decomposition:
- Shared package (rv_pkg): fetch state enum {IDLE, REQ, HOLD}, NOP constant 32'h00000013, default RESET_PC.
- One sub-module, fetch_pc. It holds the PC register and the next-PC mux (redirect_pc / PC+4 / hold), with async active-low reset. The FSM, kill flag and output registers stay in riscv_fetch.

Test Plan:
- Reset release, run=1, zero-wait memory returning addr^32'hA5A5A5A5, ir_ready=1 -> mem_addr sequence 0,4,8; ir_pc 0,4,8 with matching ir; ir_valid pulses every 2nd cycle.
- Memory ack delayed 3 cycles -> mem_req stays 1 and mem_addr stays 0 for 3 cycles; ir_valid rises on the edge after ack.
- ir_ready=0 for 5 cycles while ir_valid=1 -> ir/ir_pc stable, no new mem_req; resumes at ir_pc+4 after ready.
- Redirect to 32'h100 while in REQ at 0x8 with ack 2 cycles later -> returned data discarded, ir_valid stays 0, next mem_addr=32'h100, then ir_pc=32'h100.
- Redirect to 32'h102 -> fault=1, no further mem_req; then redirect to 32'h200 -> fault=0, fetch resumes at 32'h200.
- RESET_PC=32'hFFFFFFF8, run=1 -> fetches FFFFFFF8, FFFFFFFC, then 00000000 (wrap); assert resetn=0 mid-REQ -> mem_req and ir_valid drop immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch-stage types and constants
package rv_pkg;
   typedef enum logic [1:0] {IDLE, REQ, HOLD} fetch_state_e;
   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter register with redirect / +4 / hold next-PC mux
module fetch_pc import rv_pkg::*; #(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] target,
   output logic [31:0] pc
);
   logic [31:0] pc_n;
   always_comb pc_n = load ? target : advance ? pc + 32'd4 : pc;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) pc <= RESET_PC;
      else pc <= pc_n;
endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch: single-outstanding instruction fetch with redirect and kill of in-flight reads
module riscv_fetch import rv_pkg::*; #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            run,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] ir,
   output logic [XLEN-1:0] ir_pc,
   output logic            ir_valid,
   input  logic            ir_ready,
   output logic            fault
);
   fetch_state_e    state, state_n;
   logic            kill, kill_n, req_n, valid_n, fault_n, pc_adv;
   logic [XLEN-1:0] pc, addr_n, ir_n, ir_pc_n;

   fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
      .clock(clock), .resetn(resetn), .load(redirect), .advance(pc_adv),
      .target(redirect_pc), .pc(pc)
   );

   always_comb begin
      state_n = state;
      kill_n  = kill;
      req_n   = mem_req;
      addr_n  = mem_addr;
      ir_n    = ir;
      ir_pc_n = ir_pc;
      valid_n = ir_valid;
      pc_adv  = 1'b0;
      fault_n = redirect ? |redirect_pc[1:0] : fault;
      unique case (state)
         IDLE: if (!redirect && run && !fault) begin
            state_n = REQ;
            req_n   = 1'b1;
            addr_n  = pc;
         end
         REQ: if (mem_ack) begin
            // a request is never withdrawn; stale data is dropped on its ack
            req_n   = 1'b0;
            kill_n  = 1'b0;
            state_n = IDLE;
            if (!kill && !redirect) begin
               ir_n    = mem_rdata;
               ir_pc_n = mem_addr;
               valid_n = 1'b1;
               pc_adv  = 1'b1;
               state_n = HOLD;
            end
         end else if (redirect) kill_n = 1'b1;
         HOLD: if (redirect) begin
            valid_n = 1'b0;
            state_n = IDLE;
         end else if (ir_ready) begin
            valid_n = 1'b0;
            state_n = run ? REQ : IDLE;
            req_n   = run;
            addr_n  = run ? pc : mem_addr;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         state    <= IDLE;
         kill     <= 1'b0;
         mem_req  <= 1'b0;
         mem_addr <= RESET_PC;
         ir       <= NOP;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state    <= state_n;
         kill     <= kill_n;
         mem_req  <= req_n;
         mem_addr <= addr_n;
         ir       <= ir_n;
         ir_pc    <= ir_pc_n;
         ir_valid <= valid_n;
         fault    <= fault_n;
      end
endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: directed checks of fetch sequencing, stalls, redirect, fault and PC wrap
module tb_riscv_fetch;
   localparam logic [31:0] K = 32'hA5A5A5A5;
   logic        clock = 0, resetn = 0, run = 0, redirect = 0, mem_ack = 0, ir_ready = 1;
   logic [31:0] redirect_pc = 0, mem_rdata = 0, mem_addr, ir, ir_pc;
   logic        mem_req, ir_valid, fault;
   logic        resetn2 = 0, mem_ack2 = 0;
   logic [31:0] mem_rdata2 = 0, mem_addr2, ir2, ir_pc2;
   logic        mem_req2, ir_valid2, fault2;
   int          lat = 0, wcnt = 0, nvec = 0, nerr = 0;

   riscv_fetch dut (
      .clock(clock), .resetn(resetn), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready), .fault(fault)
   );

   riscv_fetch #(.RESET_PC(32'hFFFFFFF8)) dut2 (
      .clock(clock), .resetn(resetn2), .run(1'b1), .redirect(1'b0), .redirect_pc(32'h0),
      .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
      .ir(ir2), .ir_pc(ir_pc2), .ir_valid(ir_valid2), .ir_ready(1'b1), .fault(fault2)
   );

   always #5 clock = ~clock;

   // memory models: ack after lat waiting cycles, data = addr ^ K
   always @(negedge clock) begin
      if (mem_req) begin
         mem_ack   = (wcnt >= lat);
         mem_rdata = mem_addr ^ K;
         wcnt      = mem_ack ? 0 : wcnt + 1;
      end else begin
         mem_ack = 0;
         wcnt    = 0;
      end
      mem_ack2   = mem_req2;
      mem_rdata2 = mem_addr2 ^ K;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      tick();
      tick();
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_ir", ir, 32'h13);
      check("rst_irpc", ir_pc, 0);
      check("rst_valid", ir_valid, 0);
      check("rst_fault", fault, 0);
      check("rst2_addr", mem_addr2, 32'hFFFFFFF8);
      // zero-wait streaming
      resetn = 1;
      run    = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("seq_req", mem_req, 1);
         check("seq_addr", mem_addr, 4 * i);
         check("seq_valid_lo", ir_valid, 0);
         tick();
         check("seq_valid_hi", ir_valid, 1);
         check("seq_irpc", ir_pc, 4 * i);
         check("seq_ir", ir, (4 * i) ^ K);
         check("seq_req_lo", mem_req, 0);
      end
      run = 0;
      tick();
      check("stop_valid", ir_valid, 0);
      check("stop_req", mem_req, 0);
      // delayed ack
      resetn = 0;
      #1;
      resetn = 1;
      lat    = 3;
      run    = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("wait_req", mem_req, 1);
         check("wait_addr", mem_addr, 0);
         check("wait_valid", ir_valid, 0);
      end
      tick();
      check("ack_valid", ir_valid, 1);
      check("ack_irpc", ir_pc, 0);
      check("ack_ir", ir, K);
      // decode stall
      lat      = 0;
      ir_ready = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", ir_valid, 1);
         check("stall_irpc", ir_pc, 0);
         check("stall_ir", ir, K);
         check("stall_req", mem_req, 0);
      end
      ir_ready = 1;
      tick();
      check("resume_addr", mem_addr, 4);
      check("resume_req", mem_req, 1);
      tick();
      check("resume_irpc", ir_pc, 4);
      // redirect while request at 0x8 is outstanding
      lat = 2;
      tick();
      check("rd_addr0", mem_addr, 8);
      redirect    = 1;
      redirect_pc = 32'h100;
      tick();
      redirect = 0;
      check("rd_req_hold", mem_req, 1);
      check("rd_addr_hold", mem_addr, 8);
      tick();
      check("rd_req_hold2", mem_req, 1);
      check("rd_valid_lo", ir_valid, 0);
      tick();
      check("rd_discard_valid", ir_valid, 0);
      check("rd_discard_req", mem_req, 0);
      lat = 0;
      tick();
      check("rd_new_addr", mem_addr, 32'h100);
      check("rd_new_req", mem_req, 1);
      tick();
      check("rd_new_irpc", ir_pc, 32'h100);
      check("rd_new_ir", ir, 32'h100 ^ K);
      check("rd_new_valid", ir_valid, 1);
      // misaligned redirect from HOLD, then recovery
      redirect    = 1;
      redirect_pc = 32'h102;
      tick();
      redirect = 0;
      check("mis_fault", fault, 1);
      check("mis_valid", ir_valid, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("mis_noreq", mem_req, 0);
      end
      redirect    = 1;
      redirect_pc = 32'h200;
      tick();
      redirect = 0;
      check("fix_fault", fault, 0);
      tick();
      check("fix_addr", mem_addr, 32'h200);
      check("fix_req", mem_req, 1);
      tick();
      check("fix_irpc", ir_pc, 32'h200);
      check("fix_ir", ir, 32'h200 ^ K);
      ir_ready = 0;
      // PC wrap on the second instance
      resetn2 = 1;
      tick();
      check("wrap_a0", mem_addr2, 32'hFFFFFFF8);
      tick();
      check("wrap_pc0", ir_pc2, 32'hFFFFFFF8);
      tick();
      check("wrap_a1", mem_addr2, 32'hFFFFFFFC);
      tick();
      check("wrap_pc1", ir_pc2, 32'hFFFFFFFC);
      check("wrap_ir1", ir2, 32'hFFFFFFFC ^ K);
      tick();
      check("wrap_a2", mem_addr2, 32'h00000000);
      check("wrap_req", mem_req2, 1);
      // async reset mid-request and mid-hold, checked before any further edge
      #2;
      resetn2 = 0;
      check("hold_valid_pre", ir_valid, 1);
      resetn = 0;
      #1;
      check("arst_req2", mem_req2, 0);
      check("arst_valid2", ir_valid2, 0);
      check("arst_addr2", mem_addr2, 32'hFFFFFFF8);
      check("arst_valid", ir_valid, 0);
      check("arst_ir", ir, 32'h13);
      check("arst_fault", fault2, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
